// File: rtl/ysyx_23060020_lsu.sv
// Multi-cycle load/store unit: registers a core memory operation, issues it on a
// split request/response bus, and returns sized, extended load data or an error.
module ysyx_23060020_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic                  mem_req_wen,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [DATA_W/8-1:0]   mem_req_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_resp_rdata
);

  localparam int OFF_W  = $clog2(DATA_W/8);
  localparam int STRB_W = DATA_W/8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t              state_q;
  logic                wen_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [OFF_W-1:0]    off_q;
  logic [ADDR_W-1:0]   memAddr_q;
  logic                memWen_q;
  logic [DATA_W-1:0]   memWdata_q;
  logic [STRB_W-1:0]   memStrb_q;
  logic [DATA_W-1:0]   respData_q;
  logic                respErr_q;

  logic [OFF_W-1:0]    reqOff;
  logic                badReq;
  logic [7:0]          strbBase;
  logic [STRB_W-1:0]   reqStrb;
  logic [DATA_W-1:0]   reqWdata;
  logic [ADDR_W-1:0]   reqAddrAligned;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   mask;
  logic                signBit;
  logic [DATA_W-1:0]   loadData;

  assign reqOff         = req_addr[OFF_W-1:0];
  assign reqWdata       = req_wdata << {reqOff, 3'b000};
  assign reqAddrAligned = req_addr & ~ADDR_W'(STRB_W - 1);
  assign reqStrb        = req_wen ? STRB_W'(strbBase << reqOff) : '0;

  // Size decode for the incoming request: alignment/legality and strobe pattern.
  always_comb begin
    badReq   = 1'b0;
    strbBase = 8'h01;
    case (req_size)
      2'd0: strbBase = 8'h01;
      2'd1: begin
        strbBase = 8'h03;
        badReq   = req_addr[0];
      end
      2'd2: begin
        strbBase = 8'h0F;
        badReq   = |req_addr[1:0];
      end
      default: begin
        strbBase = 8'hFF;
        badReq   = (DATA_W == 32) || (|req_addr[2:0]);
      end
    endcase
  end

  // Load lane extraction: right-align the addressed bytes, then extend.
  always_comb begin
    shifted = mem_resp_rdata >> {off_q, 3'b000};
    mask    = '1;
    signBit = 1'b0;
    case (size_q)
      2'd0: begin
        mask    = DATA_W'(64'hFF);
        signBit = shifted[7];
      end
      2'd1: begin
        mask    = DATA_W'(64'hFFFF);
        signBit = shifted[15];
      end
      2'd2: begin
        mask    = DATA_W'(64'hFFFF_FFFF);
        signBit = shifted[31];
      end
      default: begin
        mask    = '1;
        signBit = 1'b0;
      end
    endcase
    loadData = (shifted & mask) | ((signBit && !uns_q) ? ~mask : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wen_q      <= 1'b0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      off_q      <= '0;
      memAddr_q  <= '0;
      memWen_q   <= 1'b0;
      memWdata_q <= '0;
      memStrb_q  <= '0;
      respData_q <= '0;
      respErr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            wen_q  <= req_wen;
            size_q <= req_size;
            uns_q  <= req_unsigned;
            off_q  <= reqOff;
            if (badReq) begin
              state_q    <= RESP;
              respErr_q  <= 1'b1;
              respData_q <= '0;
            end else begin
              state_q    <= REQ;
              memAddr_q  <= reqAddrAligned;
              memWen_q   <= req_wen;
              memWdata_q <= reqWdata;
              memStrb_q  <= reqStrb;
            end
          end
        end
        REQ: begin
          // Payload is held until the bus takes it, then the bus side goes quiet.
          if (mem_req_ready) begin
            state_q    <= WAIT;
            memAddr_q  <= '0;
            memWen_q   <= 1'b0;
            memWdata_q <= '0;
            memStrb_q  <= '0;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            state_q    <= RESP;
            respData_q <= wen_q ? '0 : loadData;
            respErr_q  <= 1'b0;
          end
        end
        RESP: begin
          state_q    <= IDLE;
          respData_q <= '0;
          respErr_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == IDLE) && !rst;
  assign mem_req_valid = (state_q == REQ);
  assign resp_valid    = (state_q == RESP);
  assign resp_rdata    = respData_q;
  assign resp_err      = respErr_q;
  assign mem_req_addr  = memAddr_q;
  assign mem_req_wen   = memWen_q;
  assign mem_req_wdata = memWdata_q;
  assign mem_req_wstrb = memStrb_q;

endmodule

// File: tb/tb_ysyx_23060020_lsu.sv
// Scoreboard bench for the LSU: a 32-bit instance for sizing/errors/back-pressure/reset
// and a 64-bit instance for doubleword and upper-lane loads.
module tb_ysyx_23060020_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  exp_t exp32Q[$];
  exp_t exp64Q[$];
  exp_t mon32E;
  exp_t mon64E;

  logic        req_valid = 0, req_wen = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_wen;
  logic        mem_req_ready = 0, mem_resp_valid = 0;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic [31:0] mem_resp_rdata = 0;

  logic        req_valid64 = 0, req_wen64 = 0, req_unsigned64 = 0;
  logic [1:0]  req_size64 = 0;
  logic [31:0] req_addr64 = 0;
  logic [63:0] req_wdata64 = 0;
  logic        req_ready64, resp_valid64, resp_err64;
  logic [63:0] resp_rdata64;
  logic        mem_req_valid64, mem_req_wen64;
  logic        mem_req_ready64 = 0, mem_resp_valid64 = 0;
  logic [31:0] mem_req_addr64;
  logic [63:0] mem_req_wdata64;
  logic [7:0]  mem_req_wstrb64;
  logic [63:0] mem_resp_rdata64 = 0;

  ysyx_23060020_lsu #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  ysyx_23060020_lsu #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid64), .req_ready(req_ready64), .req_wen(req_wen64), .req_size(req_size64),
    .req_unsigned(req_unsigned64), .req_addr(req_addr64), .req_wdata(req_wdata64),
    .resp_valid(resp_valid64), .resp_rdata(resp_rdata64), .resp_err(resp_err64),
    .mem_req_valid(mem_req_valid64), .mem_req_ready(mem_req_ready64), .mem_req_addr(mem_req_addr64),
    .mem_req_wen(mem_req_wen64), .mem_req_wdata(mem_req_wdata64), .mem_req_wstrb(mem_req_wstrb64),
    .mem_resp_valid(mem_resp_valid64), .mem_resp_rdata(mem_resp_rdata64)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Monitors: every response pulse must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (exp32Q.size() == 0) begin
        checkOutput("dut32 unexpected resp_valid", 64'd1, 64'd0);
      end else begin
        mon32E = exp32Q.pop_front();
        checkOutput({mon32E.name, " rdata"}, {32'd0, resp_rdata}, mon32E.rdata);
        checkOutput({mon32E.name, " err"}, {63'd0, resp_err}, {63'd0, mon32E.err});
        checkOutput({mon32E.name, " resp cycle"}, 64'(cyc), 64'(mon32E.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (resp_valid64 === 1'b1) begin
      if (exp64Q.size() == 0) begin
        checkOutput("dut64 unexpected resp_valid", 64'd1, 64'd0);
      end else begin
        mon64E = exp64Q.pop_front();
        checkOutput({mon64E.name, " rdata"}, resp_rdata64, mon64E.rdata);
        checkOutput({mon64E.name, " err"}, {63'd0, resp_err64}, {63'd0, mon64E.err});
        checkOutput({mon64E.name, " resp cycle"}, 64'(cyc), 64'(mon64E.cyc));
      end
    end
  end

  task automatic applyStimulus(input string name, input logic wen, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                               input int readyLat, input int respLat, input logic [31:0] busData,
                               input logic [31:0] expAddr, input logic [31:0] expWdata,
                               input logic [3:0] expStrb, input logic [31:0] expRdata,
                               input logic expErr);
    exp_t e;
    int   acc;
    @(posedge clk); #1;
    req_valid = 1; req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    acc = cyc;
    e.rdata = {32'd0, expRdata};
    e.err   = expErr;
    e.cyc   = expErr ? acc + 1 : acc + 3 + readyLat + respLat;
    e.name  = name;
    exp32Q.push_back(e);
    @(negedge clk);
    checkOutput({name, " req_ready idle"}, {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 0;
    if (expErr) begin
      @(negedge clk);
      checkOutput({name, " no bus req"}, {63'd0, mem_req_valid}, 64'd0);
    end else begin
      for (int i = 0; i <= readyLat; i++) begin
        mem_req_ready = (i == readyLat);
        @(negedge clk);
        checkOutput({name, " mem_req_valid"}, {63'd0, mem_req_valid}, 64'd1);
        checkOutput({name, " mem_req_addr"}, {32'd0, mem_req_addr}, {32'd0, expAddr});
        checkOutput({name, " mem_req_wdata"}, {32'd0, mem_req_wdata}, {32'd0, expWdata});
        checkOutput({name, " mem_req_wstrb"}, {60'd0, mem_req_wstrb}, {60'd0, expStrb});
        checkOutput({name, " mem_req_wen"}, {63'd0, mem_req_wen}, {63'd0, wen});
        checkOutput({name, " req_ready busy"}, {63'd0, req_ready}, 64'd0);
        @(posedge clk); #1;
      end
      mem_req_ready = 0;
      for (int i = 0; i <= respLat; i++) begin
        mem_resp_valid = (i == respLat);
        mem_resp_rdata = (i == respLat) ? busData : 32'h0;
        @(negedge clk);
        checkOutput({name, " wait quiet"}, {62'd0, mem_req_valid, req_ready}, 64'd0);
        @(posedge clk); #1;
      end
      mem_resp_valid = 0;
      mem_resp_rdata = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic run64(input string name, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [63:0] busData,
                       input logic [31:0] expAddr, input logic [63:0] expRdata);
    exp_t e;
    @(posedge clk); #1;
    req_valid64 = 1; req_wen64 = 0; req_size64 = size; req_unsigned64 = uns; req_addr64 = addr;
    e.rdata = expRdata;
    e.err   = 1'b0;
    e.cyc   = cyc + 3;
    e.name  = name;
    exp64Q.push_back(e);
    @(posedge clk); #1;
    req_valid64 = 0;
    mem_req_ready64 = 1;
    @(negedge clk);
    checkOutput({name, " mem_req_valid"}, {63'd0, mem_req_valid64}, 64'd1);
    checkOutput({name, " mem_req_addr"}, {32'd0, mem_req_addr64}, {32'd0, expAddr});
    checkOutput({name, " mem_req_wstrb"}, {56'd0, mem_req_wstrb64}, 64'd0);
    @(posedge clk); #1;
    mem_req_ready64 = 0;
    mem_resp_valid64 = 1;
    mem_resp_rdata64 = busData;
    @(posedge clk); #1;
    mem_resp_valid64 = 0;
    mem_resp_rdata64 = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset req_ready", {63'd0, req_ready}, 64'd0);
    checkOutput("reset resp_valid", {63'd0, resp_valid}, 64'd0);
    checkOutput("reset mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    checkOutput("reset mem_req_wstrb", {60'd0, mem_req_wstrb}, 64'd0);
    checkOutput("reset resp_rdata", {32'd0, resp_rdata}, 64'd0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checkOutput("post-reset req_ready", {63'd0, req_ready}, 64'd1);

    //            name             wen size uns addr          wdata         rL rV bus           expAddr       expWdata      strb     rdata         err
    applyStimulus("word load",     0, 2'd2, 0, 32'h80000004, 32'h0,        0, 0, 32'hDEADBEEF, 32'h80000004, 32'h0,        4'b0000, 32'hDEADBEEF, 0);
    applyStimulus("byte signed",   0, 2'd0, 0, 32'h80000003, 32'h0,        0, 0, 32'h80FF1234, 32'h80000000, 32'h0,        4'b0000, 32'hFFFFFF80, 0);
    applyStimulus("byte unsigned", 0, 2'd0, 1, 32'h80000003, 32'h0,        0, 0, 32'h80FF1234, 32'h80000000, 32'h0,        4'b0000, 32'h00000080, 0);
    applyStimulus("half signed",   0, 2'd1, 0, 32'h80000002, 32'h0,        0, 0, 32'h80FF1234, 32'h80000000, 32'h0,        4'b0000, 32'hFFFF80FF, 0);
    applyStimulus("half unsigned", 0, 2'd1, 1, 32'h80000002, 32'h0,        0, 0, 32'h80FF1234, 32'h80000000, 32'h0,        4'b0000, 32'h000080FF, 0);
    applyStimulus("half store",    1, 2'd1, 0, 32'h80000002, 32'h0000ABCD, 0, 0, 32'hFFFFFFFF, 32'h80000000, 32'hABCD0000, 4'b1100, 32'h0,        0);
    applyStimulus("byte store",    1, 2'd0, 0, 32'h80000001, 32'h000000A5, 1, 2, 32'h0,        32'h80000000, 32'h0000A500, 4'b0010, 32'h0,        0);
    applyStimulus("misalign word", 0, 2'd2, 0, 32'h80000001, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        1);
    applyStimulus("misalign half", 0, 2'd1, 0, 32'h80000003, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        1);
    applyStimulus("dword on 32",   0, 2'd3, 0, 32'h80000000, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        1);
    applyStimulus("backpressure",  0, 2'd2, 0, 32'h80000008, 32'h0,        5, 3, 32'h12345678, 32'h80000008, 32'h0,        4'b0000, 32'h12345678, 0);

    // Abandon a load in WAIT via asynchronous reset.
    @(posedge clk); #1;
    req_valid = 1; req_wen = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h80000010;
    @(posedge clk); #1;
    req_valid = 0;
    mem_req_ready = 1;
    @(posedge clk); #1;
    mem_req_ready = 0;
    #2;
    rst = 1;
    #1;
    checkOutput("async rst mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    checkOutput("async rst resp_valid", {63'd0, resp_valid}, 64'd0);
    checkOutput("async rst req_ready", {63'd0, req_ready}, 64'd0);
    checkOutput("async rst mem_req_addr", {32'd0, mem_req_addr}, 64'd0);
    @(posedge clk); #1;
    rst = 0;
    mem_resp_valid = 1;
    mem_resp_rdata = 32'h11112222;
    @(negedge clk);
    checkOutput("stray resp ignored", {63'd0, resp_valid}, 64'd0);
    @(posedge clk); #1;
    mem_resp_valid = 0;
    mem_resp_rdata = 0;
    @(negedge clk);
    checkOutput("stray resp no pulse", {63'd0, resp_valid}, 64'd0);
    checkOutput("after stray req_ready", {63'd0, req_ready}, 64'd1);
    applyStimulus("fresh load",    0, 2'd2, 0, 32'h80000010, 32'h0,        0, 0, 32'hCAFEF00D, 32'h80000010, 32'h0,        4'b0000, 32'hCAFEF00D, 0);

    run64("dword load 64", 2'd3, 0, 32'h80000008, 64'h0123456789ABCDEF, 32'h80000008, 64'h0123456789ABCDEF);
    run64("word hi 64",    2'd2, 0, 32'h80000004, 64'h89ABCDEF01234567, 32'h80000000, 64'hFFFFFFFF89ABCDEF);

    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("dut32 responses outstanding", 64'(exp32Q.size()), 64'd0);
    checkOutput("dut64 responses outstanding", 64'(exp64Q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
